// File: rtl/data_mem_responder_if.sv
// Request/response bus between a core's MEM stage and the data memory responder.
// The master side is the core; the slave side is the responder.
interface data_mem_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [31:0]             req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_wstrb;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [DATA_WIDTH-1:0]   resp_rdata;
  logic                    resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-port data memory that serves one load/store at a time with a fixed number
// of wait states, byte-lane stores and error reporting for bad addresses.
module data_mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  data_mem_responder_if.slave bus
);
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state;
  state_t                  next_state;
  logic [3:0]              wait_cnt;
  logic                    cap_write;
  logic [31:0]             cap_addr;
  logic [DATA_WIDTH-1:0]   cap_wdata;
  logic [NUM_LANES-1:0]    cap_wstrb;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    error_q;
  logic                    accept;
  logic                    enter_resp;

  logic                    acc_write;
  logic [31:0]             acc_addr;
  logic [DATA_WIDTH-1:0]   acc_wdata;
  logic [NUM_LANES-1:0]    acc_wstrb;
  logic                    acc_error;
  logic [DEPTH_LOG2-1:0]   acc_index;

  logic [DATA_WIDTH-1:0]   mem [0:(1<<DEPTH_LOG2)-1];

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_error = error_q;

  // With no wait states the access commits on the accept edge itself, before the
  // capture registers hold the request, so the live inputs are used in IDLE.
  assign acc_write = (state == IDLE) ? bus.req_write : cap_write;
  assign acc_addr  = (state == IDLE) ? bus.req_addr  : cap_addr;
  assign acc_wdata = (state == IDLE) ? bus.req_wdata : cap_wdata;
  assign acc_wstrb = (state == IDLE) ? bus.req_wstrb : cap_wstrb;
  assign acc_index = acc_addr[DEPTH_LOG2+1:2];
  assign acc_error = (acc_addr[1:0] != 2'b00) || (|acc_addr[31:DEPTH_LOG2+2]);

  always_comb begin
    next_state = state;
    enter_resp = 1'b0;
    accept     = bus.req_valid && (state == IDLE);
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            next_state = RESP;
            enter_resp = 1'b1;
          end else begin
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          next_state = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Memory writes live in the non-reset branch so an access in flight at reset
  // is abandoned and the array itself is never cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_wstrb <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        cap_write <= bus.req_write;
        cap_addr  <= bus.req_addr;
        cap_wdata <= bus.req_wdata;
        cap_wstrb <= bus.req_wstrb;
        wait_cnt  <= WAIT_LOAD;
      end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (enter_resp) begin
        error_q <= acc_error;
        if (acc_error || acc_write) begin
          rdata_q <= '0;
        end else begin
          rdata_q <= mem[acc_index];
        end
        if (!acc_error && acc_write) begin
          for (int b = 0; b < NUM_LANES; b++) begin
            if (acc_wstrb[b]) begin
              mem[acc_index][b*8 +: 8] <= acc_wdata[b*8 +: 8];
            end
          end
        end
      end
    end
  end
endmodule
